// File: rtl/muldiv_unit_if.sv
// Operand, control and HI/LO result bundle between the EXE stage and muldiv_unit.
// The unit takes the slave side; the pipeline control (or a bench) drives the master side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            flush;
  logic            hilo_we;
  logic            hilo_sel;
  logic [XLEN-1:0] hilo_wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush, hilo_we, hilo_sel, hilo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush, hilo_we, hilo_sel, hilo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO: fixed 34-cycle latency,
// shift-add multiply and restoring divide on magnitudes, signs fixed up afterwards.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  muldiv_unit_if.slave  md_if
);

  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     rs_orig_q, rs_orig_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Operand magnitudes and sign flags, only meaningful on the launch edge.
  logic                signed_op_s;
  logic                rs_neg_s;
  logic                rt_neg_s;
  logic [XLEN-1:0]     rs_mag_s;
  logic [XLEN-1:0]     rt_mag_s;

  // Per-iteration datapath: acc holds {partial product, multiplier} or {-, quotient/dividend}.
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN+1:0]     div_shift_s;
  logic                div_ge_s;
  logic [XLEN:0]       div_diff_s;

  assign signed_op_s = ~md_if.op[0];
  assign rs_neg_s    = signed_op_s & md_if.rs_data[XLEN-1];
  assign rt_neg_s    = signed_op_s & md_if.rt_data[XLEN-1];
  assign rs_mag_s    = rs_neg_s ? -md_if.rs_data : md_if.rs_data;
  assign rt_mag_s    = rt_neg_s ? -md_if.rt_data : md_if.rt_data;

  assign mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign div_shift_s = {rem_q, acc_q[XLEN-1]};
  assign div_ge_s    = (div_shift_s >= {2'b00, opb_q});
  assign div_diff_s  = div_shift_s[XLEN:0] - {1'b0, opb_q};

  // Next-state and datapath update for the whole unit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opb_d     = opb_q;
    rs_orig_d = rs_orig_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (md_if.hilo_we) begin
          if (md_if.hilo_sel) begin
            hi_d = md_if.hilo_wdata;
          end else begin
            lo_d = md_if.hilo_wdata;
          end
        end else begin
          hi_d = hi_q;
        end
        if (md_if.start && !md_if.flush) begin
          state_d   = S_ITER;
          cnt_d     = CNT_W'(ITER);
          is_div_d  = md_if.op[1];
          neg_res_d = rs_neg_s ^ rt_neg_s;
          neg_rem_d = rs_neg_s;
          div0_d    = (md_if.rt_data == {XLEN{1'b0}});
          rs_orig_d = md_if.rs_data;
          rem_d     = {(XLEN+1){1'b0}};
          if (md_if.op[1]) begin
            opb_d = rt_mag_s;
            acc_d = {{XLEN{1'b0}}, rs_mag_s};
          end else begin
            opb_d = rs_mag_s;
            acc_d = {{XLEN{1'b0}}, rt_mag_s};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (md_if.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge_s};
            if (div_ge_s) begin
              rem_d = div_diff_s;
            end else begin
              rem_d = div_shift_s[XLEN:0];
            end
          end else begin
            acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_FIX: begin
        if (md_if.flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
          // Divide by zero reports the untouched dividend in HI and all ones in LO.
          if (is_div_q && div0_q) begin
            acc_d = {rs_orig_q, {XLEN{1'b1}}};
          end else if (is_div_q) begin
            acc_d = {(neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0]),
                     (neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0])};
          end else begin
            acc_d = neg_res_q ? -acc_q : acc_q;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (md_if.flush) begin
          done_d = 1'b0;
        end else begin
          hi_d   = acc_q[2*XLEN-1:XLEN];
          lo_d   = acc_q[XLEN-1:0];
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opb_q     <= {XLEN{1'b0}};
      rs_orig_q <= {XLEN{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      rem_q     <= {(XLEN+1){1'b0}};
      hi_q      <= {XLEN{1'b0}};
      lo_q      <= {XLEN{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opb_q     <= opb_d;
      rs_orig_q <= rs_orig_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign md_if.busy = busy_q;
  assign md_if.done = done_q;
  assign md_if.hi   = hi_q;
  assign md_if.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops,
// compared against an arithmetic reference model and a HI/LO scoreboard.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit_if #(.XLEN(XLEN)) md_if ();

  muldiv_unit #(.XLEN(XLEN), .ITER(32)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .md_if   (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: HI/LO pair straight from integer arithmetic on the operands.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = 64'(sa * sb); return p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          m = sa % sb;
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          m = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        p = {m[31:0], q[31:0]};
        return p;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_busy", 64'(md_if.busy), 64'd0);
      check("idle_done", 64'(md_if.done), 64'd0);
      check("idle_hilo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});
    end
  endtask

  // Launch an op now (sampled at E0) and follow it to E34.
  // poke: edge at which a stray start/hilo_we is driven while busy; we_launch: mtlo on the launch edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input bit we_launch);
    logic [63:0] r;
    logic [31:0] wd;
    r = ref_op(op, a, b);
    wd = $urandom;
    md_if.op = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    md_if.start = 1'b1;
    md_if.hilo_we = we_launch;
    md_if.hilo_sel = 1'b0;
    md_if.hilo_wdata = wd;
    step();
    md_if.start = 1'b0;
    md_if.hilo_we = 1'b0;
    if (we_launch) exp_lo = wd;
    check("launch_busy", 64'(md_if.busy), 64'd1);
    check("launch_done", 64'(md_if.done), 64'd0);
    check("launch_hilo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});
    for (int k = 1; k <= 34; k++) begin
      if (poke != 0 && (k == poke || k == 34)) begin
        md_if.start = (k == poke);
        md_if.op = 2'($urandom);
        md_if.rs_data = $urandom;
        md_if.rt_data = $urandom;
        md_if.hilo_we = 1'b1;
        md_if.hilo_sel = 1'($urandom);
        md_if.hilo_wdata = $urandom;
      end
      step();
      md_if.start = 1'b0;
      md_if.hilo_we = 1'b0;
      if (k < 34) begin
        check("run_busy", 64'(md_if.busy), 64'd1);
        check("run_done", 64'(md_if.done), 64'd0);
        if (k == 33) check("run_hilo_held", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});
      end else begin
        check("wb_busy", 64'(md_if.busy), 64'd0);
        check("wb_done", 64'(md_if.done), 64'd1);
        check("wb_result", {md_if.hi, md_if.lo}, r);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end
    end
  endtask

  // Launch an op and kill it with flush or reset sampled at edge 'at'.
  task automatic run_abort(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int at, input bit use_reset);
    md_if.op = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    md_if.start = 1'b1;
    step();
    md_if.start = 1'b0;
    for (int k = 1; k < at; k++) step();
    check("abort_busy_before", 64'(md_if.busy), 64'd1);
    if (use_reset) reset = 1'b1;
    else md_if.flush = 1'b1;
    step();
    reset = 1'b0;
    md_if.flush = 1'b0;
    if (use_reset) begin
      exp_hi = 32'd0;
      exp_lo = 32'd0;
    end
    check("abort_busy", 64'(md_if.busy), 64'd0);
    check("abort_hilo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});
    idle(40);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    md_if.start = 1'b0;
    md_if.op = 2'd0;
    md_if.rs_data = 32'd0;
    md_if.rt_data = 32'd0;
    md_if.flush = 1'b0;
    md_if.hilo_we = 1'b0;
    md_if.hilo_sel = 1'b0;
    md_if.hilo_wdata = 32'd0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    step();
    step();
    check("reset_state", {md_if.busy, md_if.done, md_if.hi, md_if.lo}, 66'd0);
    reset = 1'b0;
    idle(2);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max_const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFE_0000_0001);
    idle(2);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
    check("mult_neg_const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("div_neg_const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd7, 32'd0, 0, 1'b0);
    check("divu_zero_const", {md_if.hi, md_if.lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("div_ovf_const", {md_if.hi, md_if.lo}, 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'hFFFF_FFF7, 32'd0, 0, 1'b0);
    idle(1);

    // Stray start at E5 and hilo_we while busy / on the WB edge are ignored.
    run_op(2'd1, 32'd6, 32'd7, 5, 1'b0);
    check("multu_6x7_const", {md_if.hi, md_if.lo}, 64'd42);
    idle(1);
    md_if.hilo_we = 1'b1;
    md_if.hilo_sel = 1'b1;
    md_if.hilo_wdata = 32'hA5A5_A5A5;
    step();
    md_if.hilo_we = 1'b0;
    exp_hi = 32'hA5A5_A5A5;
    check("mthi", {md_if.hi, md_if.lo}, {32'hA5A5_A5A5, 32'd42});
    md_if.hilo_we = 1'b1;
    md_if.hilo_sel = 1'b0;
    md_if.hilo_wdata = 32'h1234_5678;
    step();
    md_if.hilo_we = 1'b0;
    exp_lo = 32'h1234_5678;
    check("mtlo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});

    // flush with start in IDLE: no launch.
    md_if.start = 1'b1;
    md_if.flush = 1'b1;
    md_if.op = 2'd3;
    md_if.rs_data = 32'd9;
    md_if.rt_data = 32'd2;
    step();
    md_if.start = 1'b0;
    md_if.flush = 1'b0;
    check("flush_start_busy", 64'(md_if.busy), 64'd0);
    idle(40);

    run_abort(2'd2, 32'd100, 32'd3, 11, 1'b0);
    run_abort(2'd2, 32'd100, 32'd3, 21, 1'b1);

    // Back-to-back: second op launches on the edge right after done.
    run_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
    check("divu_100_7_const", {md_if.hi, md_if.lo}, {32'd2, 32'd14});
    run_op(2'd0, 32'h7FFF_0001, 32'hFFFF_8000, 0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = rb >> $urandom_range(1, 31);
        default: rb = rb;
      endcase
      run_op(rop, ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 33)) : 0, 1'($urandom));
      if (i % 2 == 0) idle(1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
